// File: rtl/gfx_cmd_scheduler.sv
// rtl/gfx_cmd_scheduler.sv - queues rectangle fill/draw commands and sequences them into graphics_processor
module gfx_cmd_scheduler #(
  parameter int DEPTH   = 4,
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int TIMEOUT = 1048576
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_op,
  input  logic [9:0]               cmd_tl_x,
  input  logic [8:0]               cmd_tl_y,
  input  logic [9:0]               cmd_br_x,
  input  logic [8:0]               cmd_br_y,
  input  logic [11:0]              cmd_arg,
  input  logic                     flush,
  output logic [31:0]              ctrl_out,
  output logic [31:0]              tl_out,
  output logic [31:0]              br_out,
  output logic [31:0]              arg_out,
  output logic                     ctrl_we,
  output logic                     tl_we,
  output logic                     br_we,
  output logic                     arg_we,
  input  logic                     gp_finish,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     done,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int EW = 51;

  localparam logic [PW-1:0] P_DEPTH  = PW'(DEPTH);
  localparam logic [10:0]   X_LIM    = 11'(WIDTH);
  localparam logic [9:0]    Y_LIM    = 10'(HEIGHT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LOAD, S_START, S_WAIT, S_STOP, S_GAP
  } state_t;

  state_t          r_state;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_count;
  logic            r_op;
  logic [9:0]      r_tl_x;
  logic [8:0]      r_tl_y;
  logic [9:0]      r_br_x;
  logic [8:0]      r_br_y;
  logic [11:0]     r_arg;
  logic [CW-1:0]   r_cnt;

  logic            w_ready;
  logic            w_push;
  logic            w_pop;
  logic            w_invalid;
  logic            w_timeout;
  logic            w_en;
  logic [EW-1:0]   w_entry;

  assign w_entry   = {cmd_op, cmd_tl_x, cmd_tl_y, cmd_br_x, cmd_br_y, cmd_arg};
  assign w_ready   = (r_count < P_DEPTH);
  // A push coinciding with flush is dropped along with the queued entries.
  assign w_push    = cmd_valid && w_ready && !flush;
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
  assign w_invalid = (r_tl_x > r_br_x) || (r_tl_y > r_br_y) ||
                     ({1'b0, r_br_x} >= X_LIM) || ({1'b0, r_br_y} >= Y_LIM);
  assign w_timeout = (r_state == S_WAIT) && !gp_finish && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + PW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= 1'b0;
      r_tl_x  <= '0;
      r_tl_y  <= '0;
      r_br_x  <= '0;
      r_br_y  <= '0;
      r_arg   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_op, r_tl_x, r_tl_y, r_br_x, r_br_y, r_arg} <= r_mem[r_rd_ptr];
            r_state <= S_CHECK;
          end
        end
        S_CHECK: r_state <= w_invalid ? S_IDLE : S_LOAD;
        S_LOAD:  r_state <= S_START;
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (gp_finish || (r_cnt == CNT_LAST)) begin
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP:  r_state <= S_GAP;
        // GAP lets graphics_processor see en low on an edge before the next command.
        S_GAP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Holding ctrl_we high with ctrl_out zero during reset parks graphics_processor.
  assign w_en      = rst_n && ((r_state == S_START) || (r_state == S_WAIT));
  assign ctrl_out  = {30'b0, w_en, w_en & r_op};
  assign ctrl_we   = !rst_n || (r_state == S_START) || (r_state == S_STOP);
  assign tl_we     = rst_n && (r_state == S_LOAD);
  assign br_we     = rst_n && (r_state == S_LOAD);
  assign arg_we    = rst_n && (r_state == S_LOAD);
  assign tl_out    = rst_n ? {6'b0, r_tl_x, 7'b0, r_tl_y} : 32'b0;
  assign br_out    = rst_n ? {6'b0, r_br_x, 7'b0, r_br_y} : 32'b0;
  assign arg_out   = rst_n ? {20'b0, r_arg} : 32'b0;
  assign done      = rst_n && (r_state == S_WAIT) && gp_finish;
  assign err       = rst_n && (((r_state == S_CHECK) && w_invalid) || w_timeout);
  assign busy      = rst_n && ((r_state != S_IDLE) || (r_count != '0));
  assign pending   = rst_n ? r_count : '0;
  assign cmd_ready = rst_n && w_ready;

endmodule

// File: tb/tb_gfx_cmd_scheduler.sv
// tb/tb_gfx_cmd_scheduler.sv - scoreboard bench for gfx_cmd_scheduler
module tb_gfx_cmd_scheduler;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [9:0]  cmd_tl_x = '0;
  logic [8:0]  cmd_tl_y = '0;
  logic [9:0]  cmd_br_x = '0;
  logic [8:0]  cmd_br_y = '0;
  logic [11:0] cmd_arg = '0;
  logic        flush = 1'b0;
  logic [31:0] ctrl_out, tl_out, br_out, arg_out;
  logic        ctrl_we, tl_we, br_we, arg_we;
  logic        gp_finish = 1'b0;
  logic        busy;
  logic [2:0]  pending;
  logic        done, err;

  gfx_cmd_scheduler #(.DEPTH(DEPTH), .WIDTH(640), .HEIGHT(480), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_tl_x(cmd_tl_x), .cmd_tl_y(cmd_tl_y),
    .cmd_br_x(cmd_br_x), .cmd_br_y(cmd_br_y), .cmd_arg(cmd_arg), .flush(flush),
    .ctrl_out(ctrl_out), .tl_out(tl_out), .br_out(br_out), .arg_out(arg_out),
    .ctrl_we(ctrl_we), .tl_we(tl_we), .br_we(br_we), .arg_we(arg_we),
    .gp_finish(gp_finish), .busy(busy), .pending(pending), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // kind: 0 = completes with done, 1 = rejected in CHECK, 2 = watchdog timeout
  typedef struct {
    int          kind;
    logic [31:0] tl;
    logic [31:0] br;
    logic [31:0] arg;
    logic [31:0] ctrl;
    int          push_cyc;
    bit          lat;
    bit          b2b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   gp_hang = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at cycle %0d", name, act, req, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Graphics processor model: finish pulses 6 cycles after START unless hung.
  initial begin
    int gp_cnt;
    gp_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      gp_finish = 1'b0;
      if (!rst_n) begin
        gp_cnt = 0;
      end else if (ctrl_we && ctrl_out[1]) begin
        gp_cnt = gp_hang ? 0 : 6;
      end else if (gp_cnt > 0) begin
        gp_cnt--;
        if (gp_cnt == 0) gp_finish = 1'b1;
      end
    end
  end

  initial begin
    exp_t h;
    bit   started, exp_stop, after_load;
    int   start_cyc, last_end, ak;
    started = 0; exp_stop = 0; after_load = 0; start_cyc = 0; last_end = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        started = 0; exp_stop = 0; after_load = 0;
      end else begin
        if (exp_stop) begin
          check("stop_ctrl_we", 32'(ctrl_we), 1);
          check("stop_ctrl_out", ctrl_out, 0);
          exp_stop = 0;
        end
        if (tl_we || br_we || arg_we) begin
          if (exp_q.size() == 0) begin
            check("load_unexpected", {29'b0, tl_we, br_we, arg_we}, 0);
          end else begin
            h = exp_q[0];
            check("load_strobes", {29'b0, tl_we, br_we, arg_we}, 7);
            check("load_on_invalid", 32'(h.kind == 1), 0);
            check("tl_out", tl_out, h.tl);
            check("br_out", br_out, h.br);
            check("arg_out", arg_out, h.arg);
            if (h.lat) check("load_latency", cyc - h.push_cyc, 2);
          end
          after_load = 1;
        end else if (after_load) begin
          check("load_single_cycle", {29'b0, tl_we, br_we, arg_we}, 0);
          after_load = 0;
        end
        if (ctrl_we && ctrl_out[1]) begin
          if (exp_q.size() == 0) begin
            check("start_unexpected", ctrl_out, 0);
          end else begin
            h = exp_q[0];
            check("start_ctrl", ctrl_out, h.ctrl);
            check("start_on_invalid", 32'(h.kind == 1), 0);
            if (h.lat) check("start_latency", cyc - h.push_cyc, 3);
            if (h.b2b) check("cmd_gap", cyc - last_end, 6);
          end
          started = 1;
          start_cyc = cyc;
        end
        if (done || err) begin
          check("done_err_exclusive", 32'(done && err), 0);
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", {30'b0, done, err}, 0);
          end else begin
            h = exp_q.pop_front();
            ak = done ? 0 : (started ? 2 : 1);
            check("result_kind", ak, h.kind);
            if (started) check("finish_latency", cyc - start_cyc, (h.kind == 2) ? TIMEOUT : 6);
          end
          if (started) begin
            exp_stop = 1;
            last_end = cyc;
          end
          started = 0;
        end
      end
    end
  end

  task automatic push_cmd(input logic op, input logic [9:0] tlx, input logic [8:0] tly,
                          input logic [9:0] brx, input logic [8:0] bry, input logic [11:0] arg,
                          input int kind, input bit lat, input bit b2b);
    exp_t e;
    int   n;
    cmd_valid = 1'b1; cmd_op = op; cmd_tl_x = tlx; cmd_tl_y = tly;
    cmd_br_x = brx; cmd_br_y = bry; cmd_arg = arg;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("push_accept", 32'(cmd_ready), 1);
    e.kind = kind;
    e.tl = {6'b0, tlx, 7'b0, tly};
    e.br = {6'b0, brx, 7'b0, bry};
    e.arg = {20'b0, arg};
    e.ctrl = {30'b0, 1'b1, op};
    e.push_cyc = cyc + 1;
    e.lat = lat;
    e.b2b = b2b;
    if (cmd_ready) exp_q.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_wait();
    int n;
    n = 0;
    while (!(ctrl_out[1] && !ctrl_we) && n < 60) begin
      @(posedge clk); #1; n++;
    end
    check("reach_wait", 32'(ctrl_out[1] && !ctrl_we), 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(posedge clk); #1; n++;
    end
    repeat (2) begin @(posedge clk); #1; end
    check("return_idle", 32'(busy), 0);
    check("idle_pending", 32'(pending), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish actual=hang required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) begin @(posedge clk); #1; end
    check("rst_ctrl_we", 32'(ctrl_we), 1);
    check("rst_ctrl_out", ctrl_out, 0);
    check("rst_busy_pending", {28'b0, busy, pending}, 0);
    check("rst_pulses", {30'b0, done, err}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ctrl_we", 32'(ctrl_we), 0);
    check("idle_cmd_ready", 32'(cmd_ready), 1);

    // Single fill with hand-computed register images
    push_cmd(1'b0, 10'd10, 9'd20, 10'd12, 9'd21, 12'hF00, 0, 1, 0);
    n = 0;
    while (!arg_we && n < 10) begin @(posedge clk); #1; n++; end
    check("t1_tl_out", tl_out, 32'h000A0014);
    check("t1_br_out", br_out, 32'h000C0015);
    check("t1_arg_out", arg_out, 32'h00000F00);
    wait_idle();

    // Backlog: FIFO fills while the first command waits, sixth push stalls
    push_cmd(1'b1, 10'd0, 9'd0, 10'd639, 9'd479, 12'h101, 0, 0, 0);
    wait_wait();
    push_cmd(1'b0, 10'd1, 9'd1, 10'd2, 9'd2, 12'h102, 0, 0, 1);
    push_cmd(1'b1, 10'd3, 9'd3, 10'd4, 9'd4, 12'h103, 0, 0, 1);
    push_cmd(1'b0, 10'd5, 9'd5, 10'd6, 9'd6, 12'h104, 0, 0, 1);
    push_cmd(1'b1, 10'd7, 9'd7, 10'd8, 9'd8, 12'h105, 0, 0, 1);
    check("full_cmd_ready", 32'(cmd_ready), 0);
    check("full_pending", 32'(pending), 4);
    push_cmd(1'b0, 10'd9, 9'd9, 10'd9, 9'd9, 12'h106, 0, 0, 1);
    wait_idle();

    // Invalid rectangles followed by a valid one
    push_cmd(1'b0, 10'd50, 9'd0, 10'd40, 9'd5, 12'h201, 1, 0, 0);
    push_cmd(1'b0, 10'd0, 9'd0, 10'd10, 9'd480, 12'h202, 1, 0, 0);
    push_cmd(1'b1, 10'd5, 9'd5, 10'd6, 9'd6, 12'h203, 0, 0, 0);
    wait_idle();

    // Watchdog timeout
    gp_hang = 1'b1;
    push_cmd(1'b0, 10'd1, 9'd1, 10'd2, 9'd2, 12'h301, 2, 1, 0);
    wait_idle();
    gp_hang = 1'b0;

    // Flush during WAIT leaves the in-flight command alone
    push_cmd(1'b0, 10'd0, 9'd0, 10'd3, 9'd3, 12'h401, 0, 1, 0);
    wait_wait();
    push_cmd(1'b0, 10'd1, 9'd0, 10'd3, 9'd3, 12'h402, 0, 0, 0);
    push_cmd(1'b0, 10'd2, 9'd0, 10'd3, 9'd3, 12'h403, 0, 0, 0);
    push_cmd(1'b0, 10'd3, 9'd0, 10'd3, 9'd3, 12'h404, 0, 0, 0);
    flush = 1'b1;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_pending", 32'(pending), 0);
    check("flush_busy_inflight", 32'(busy), 1);
    wait_idle();

    // Reset in the middle of WAIT
    push_cmd(1'b1, 10'd0, 9'd0, 10'd9, 9'd9, 12'h501, 0, 1, 0);
    wait_wait();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("midrst_ctrl_we", 32'(ctrl_we), 1);
      check("midrst_ctrl_out", ctrl_out, 0);
      check("midrst_data", tl_out | br_out | arg_out, 0);
      check("midrst_flags", {25'b0, tl_we, br_we, arg_we, done, err, busy, cmd_ready}, 0);
      check("midrst_pending", 32'(pending), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    check("post_rst_busy", 32'(busy), 0);
    push_cmd(1'b0, 10'd2, 9'd2, 10'd4, 9'd4, 12'h601, 0, 1, 0);
    wait_idle();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
